// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and LFSR definition for the line-memory responder.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 28;
  localparam int unsigned MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_lfsr16.sv
// 16-bit Fibonacci LFSR used to jitter the responder's access latency.
module mem_lfsr16
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LFSR_SEED;
    end else if (en) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mem_responder.sv
// Line-array main memory behind the L2 with programmable latency, one request in flight.
// Optional latency jitter (LATENCY..LATENCY+3) is enabled by defining MEM_JITTER_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 9;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, load_cnt;
  logic [IDX_W-1:0]  idx_q, rd_idx;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              write_q, err_q, accept, rd_write;
  logic [DATA_W-1:0] mem_array [DEPTH];

  // Upper address bits alias onto the same lines.
  logic unused_addr;
  assign unused_addr = ^mem_addr;

`ifdef MEM_JITTER_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  mem_lfsr16 u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (1'b1),
    .state  (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:2];
  assign load_cnt    = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign load_cnt = CNT_W'(LATENCY - 1);
`endif

  assign accept   = (state_q == S_IDLE) && (mem_read || mem_write);
  // With a zero load count RESP follows acceptance directly, before idx_q/write_q are valid.
  assign rd_idx   = accept ? mem_addr[IDX_W-1:0] : idx_q;
  assign rd_write = accept ? mem_write : write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          cnt_d   = load_cnt;
          state_d = (load_cnt == '0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= mem_addr[IDX_W-1:0];
        wdata_q <= mem_wdata;
        write_q <= mem_write;
        if (mem_read && mem_write) err_q <= 1'b1;
      end
      if (state_d == S_RESP && !rd_write) rdata_q <= mem_array[rd_idx];
    end
  end

  // Commit on the edge leaving RESP; a reset while busy forces IDLE so no commit happens.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && write_q) mem_array[idx_q] <= wdata_q;
  end

  assign mem_ready = (state_q == S_RESP);
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expectations, a monitor checks each ready.
module tb_mem_responder;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_ready, mem_err;

  logic         r1_read = 1'b0, r1_write = 1'b0;
  logic [27:0]  r1_addr = '0;
  logic [127:0] r1_wdata = '0;
  logic [127:0] r1_rdata;
  logic         r1_ready, r1_err;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(28), .DATA_W(128), .DEPTH(1024), .LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err)
  );

  mem_responder #(.ADDR_W(28), .DATA_W(128), .DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_read(r1_read), .mem_write(r1_write),
    .mem_addr(r1_addr), .mem_wdata(r1_wdata), .mem_rdata(r1_rdata),
    .mem_ready(r1_ready), .mem_err(r1_err)
  );

  typedef struct {
    bit           is_read;
    bit           known;
    logic [127:0] data;
    int           accept;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] model [1024];
  bit           known [1024];
  int           vectors = 0, miscompares = 0;
  int           cyc = 0;
  int           last_ready = -1000;
  int           hist [4];
  exp_t         mon_e;
  int           mon_lat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void chk_range(string name, int got, int lo, int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n && mem_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_ready: got ready=1 at cycle %0d expected no request pending", cyc);
      end else begin
        mon_e   = sbq.pop_front();
        mon_lat = cyc - mon_e.accept + 1;
`ifdef MEM_JITTER_EN
        chk_range("latency", mon_lat, L, L + 3);
        if (mon_lat >= L && mon_lat <= L + 3) hist[mon_lat-L]++;
`else
        chk_range("latency", mon_lat, L, L);
`endif
        if (mon_e.is_read && mon_e.known) chk("rdata", mem_rdata, mon_e.data);
        if (last_ready >= 0) chk_range("ready_spacing", cyc - last_ready, L + 1, 1 << 20);
      end
      last_ready = cyc;
    end
  end

  // Called at a negedge while the DUT is idle; acceptance happens on the next posedge.
  task automatic issue(input bit rd, input bit wr, input logic [27:0] a,
                       input logic [127:0] d, input bit keep);
    exp_t e;
    int   t;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    e.is_read = rd && !wr;
    e.accept  = cyc + 1;
    e.known   = 1'b0;
    e.data    = '0;
    if (wr) begin
      model[a[9:0]] = d;
      known[a[9:0]] = 1'b1;
    end else begin
      e.known = known[a[9:0]];
      e.data  = model[a[9:0]];
    end
    sbq.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_ready && t < 300);
    chk("ready_seen", mem_ready, 1'b1);
    if (!keep) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  task automatic r1_op(input bit wr, input logic [27:0] a, input logic [127:0] d,
                       output int lat);
    r1_read  = !wr;
    r1_write = wr;
    r1_addr  = a;
    r1_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!r1_ready && lat < 8);
    r1_read  = 1'b0;
    r1_write = 1'b0;
  endtask

  function automatic logic [27:0] rand_addr();
    return {16'h0, 2'($urandom), 4'h0, 6'($urandom)};
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pat, va, vb, prior;
    int           lat;
    bit           rd;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 0;

    // Reset: outputs zero while held and afterwards with no spurious ready.
    repeat (3) begin
      @(negedge clk);
      chk("reset_ready", mem_ready, 1'b0);
      chk("reset_rdata", mem_rdata, '0);
      chk("reset_err", mem_err, 1'b0);
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_ready", mem_ready, 1'b0);
    end
    chk("idle_rdata", mem_rdata, '0);
    chk("idle_err", mem_err, 1'b0);

    // LATENCY=1 instance: ready in the cycle after acceptance.
    pat = rand_data();
    r1_op(1'b1, 28'h9, pat, lat);
`ifdef MEM_JITTER_EN
    chk_range("l1_write_latency", lat, 1, 4);
`else
    chk_range("l1_write_latency", lat, 1, 1);
`endif
    @(negedge clk);
    chk("l1_ready_pulse", r1_ready, 1'b0);
    r1_op(1'b0, 28'h9, '0, lat);
`ifdef MEM_JITTER_EN
    chk_range("l1_read_latency", lat, 1, 4);
`else
    chk_range("l1_read_latency", lat, 1, 1);
`endif
    chk("l1_rdata", r1_rdata, pat);
    chk("l1_err", r1_err, 1'b0);

    // Write then read back.
    pat = 128'hDEADBEEF_00000000_00000000_00000001;
    @(negedge clk);
    issue(1'b0, 1'b1, 28'h10, pat, 1'b0);
    @(negedge clk);
    issue(1'b1, 1'b0, 28'h10, '0, 1'b0);

    // Back-to-back with the read held through the edge leaving RESP.
    @(negedge clk);
    issue(1'b1, 1'b0, 28'h10, '0, 1'b1);
    @(negedge clk);
    issue(1'b1, 1'b0, 28'h10, '0, 1'b0);

    // Aliasing: 0x005 and 0x405 share a line.
    va = rand_data();
    vb = rand_data();
    @(negedge clk);
    issue(1'b0, 1'b1, 28'h005, va, 1'b0);
    @(negedge clk);
    issue(1'b0, 1'b1, 28'h405, vb, 1'b0);
    @(negedge clk);
    issue(1'b1, 1'b0, 28'h005, '0, 1'b0);

    // Read and write together: performed as a write, error flag sticks.
    @(negedge clk);
    issue(1'b1, 1'b1, 28'h3, rand_data(), 1'b0);
    @(negedge clk);
    chk("err_set", mem_err, 1'b1);
    issue(1'b1, 1'b0, 28'h3, '0, 1'b0);
    @(negedge clk);
    chk("err_sticky", mem_err, 1'b1);

    // Reset during a busy write drops it and clears the error flag.
    prior = rand_data();
    issue(1'b0, 1'b1, 28'h7, prior, 1'b0);
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'h7;
    mem_wdata = ~prior;
    repeat (3) @(negedge clk);
    reset_n   = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_ready", mem_ready, 1'b0);
    chk("abort_err", mem_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 28'h7, '0, 1'b0);
    chk("post_reset_err", mem_err, 1'b0);

    // Prefill the random working set, then random mixed traffic.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      issue(1'b0, 1'b1, 28'(i), rand_data(), 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rd = $urandom_range(0, 1) == 1;
      issue(rd, !rd, rand_addr(), rand_data(), $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      issue(1'b1, 1'b0, rand_addr(), '0, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk_range("scoreboard_drained", sbq.size(), 0, 0);
`ifdef MEM_JITTER_EN
    for (int i = 0; i < 4; i++) chk_range("jitter_value_seen", hist[i], 1, 1 << 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 128-bit line protocol that the cache hierarchy drives: mem_read, mem_write, mem_addr, mem_wdata in; mem_rdata, mem_ready out.
- Serves as main memory behind the L2 cache. It is a synthesizable line-array memory with programmable access latency.
- One request in flight at a time. mem_ready pulses exactly once per accepted request.

Parameters:
- ADDR_W, 28, line-address width (matches cache mem_addr).
- DATA_W, 128, line width in bits.
- DEPTH, 1024, lines stored. Power of two. Index = mem_addr[log2(DEPTH)-1:0]; upper bits ignored, so the address space aliases.
- LATENCY, 8, cycles from acceptance edge to mem_ready high. Legal range 1..255.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- mem_read, input, 1, read request; held by initiator until mem_ready.
- mem_write, input, 1, write request; held by initiator until mem_ready.
- mem_addr, input, ADDR_W, line address.
- mem_wdata, input, DATA_W, write line.
- mem_rdata, output, DATA_W, read line; valid only while mem_ready=1.
- mem_ready, output, 1, one-cycle completion pulse.
- mem_err, output, 1, sticky flag: read and write were both high at acceptance.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Outputs: mem_ready=0, mem_rdata=0, mem_err=0.
  - FSM goes to IDLE and the latency counter clears.
  - Array contents are not reset.
- FSM states and transitions:
  - IDLE: on an edge with (mem_read|mem_write)=1, latch addr, wdata and op into request registers. Load cnt=LATENCY-1. Go to BUSY, or directly to RESP if LATENCY=1.
  - BUSY: decrement cnt each edge. When cnt==0 go to RESP.
  - RESP: mem_ready=1 for exactly this cycle.
    - Read: mem_rdata = array[latched idx], registered on entry to RESP.
    - Write: the array is written on the edge leaving RESP.
    - Next state is always IDLE.
- Latency: request sampled at edge E0; mem_ready high during the cycle after edge E0+LATENCY-1, i.e. LATENCY cycles after acceptance.
- The edge leaving RESP never accepts a request. This prevents re-acceptance while the initiator is still dropping its request. Minimum spacing between back-to-back ready pulses is LATENCY+1 cycles.
- Input changes during BUSY/RESP are ignored; only latched values are used.
- Simultaneous read and write at acceptance: treated as write, and mem_err is set sticky until reset.
- Read-after-write to the same line returns the new data. The write commits before IDLE, so no hazard exists.
- Address aliasing: addr and addr+DEPTH map to the same line.
- Reset mid-operation: the in-flight request is dropped. A pending write is not committed and no mem_ready is produced.
- mem_rdata holds its last value outside RESP. The initiator must not sample it then.

Optional Feature:
- Macro: MEM_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - At acceptance, lfsr[1:0] is added to the loaded count, so effective latency is LATENCY..LATENCY+3.
  - This stresses initiator stall logic.
- When undefined: latency is fixed at LATENCY and no LFSR logic exists.

Decomposition:
- Package mem_pkg:
  - Constants: MEM_ADDR_W=28, MEM_DATA_W=128.
  - FSM state encodings: S_IDLE=2'd0, S_BUSY=2'd1, S_RESP=2'd2.
  - LFSR seed and taps.
- One natural sub-module: mem_lfsr16 (enable, state out). Instantiated only under MEM_JITTER_EN.
- The array stays inline as a reg array.

Test Plan:
- Reset → outputs zero: hold reset_n=0 for 3 cycles, release → mem_ready=0, mem_rdata=0, mem_err=0 throughout; no spurious ready in the next 20 cycles.
- Write then read, LATENCY=8:
  - Write addr 28'h10 with 128'hDEADBEEF_...01 → mem_ready high exactly 8 cycles after acceptance, for 1 cycle.
  - Read addr 28'h10 → same 128-bit value returned with mem_ready.
- Back-to-back held requests: initiator keeps mem_read high one cycle after ready → exactly one ready pulse per request; the second request is accepted on the following IDLE edge with ready spacing ≥ 9 cycles.
- Aliasing with DEPTH=1024: write 28'h005 = A, write 28'h405 = B, read 28'h005 → B.
- Error and reset abort:
  - read+write together on addr 3 → write performed, mem_err=1 and stays 1.
  - Assert reset_n=0 during a BUSY write to addr 7 → after reset, a read of addr 7 returns prior contents and mem_err=0.
- LATENCY=1, plus MEM_JITTER_EN:
  - LATENCY=1: ready in the cycle after acceptance.
  - With MEM_JITTER_EN: 1000 reads all show latency within 8..11 and all 4 values occur.
